mpu_axis_monitor: RTL and testbench
===================================

// Module: mpu_axis_monitor
// PURPOSE
//  Parametrised successor to the MPU6050 demo indicator logic. Sits between the MPU6050
//  sample reader and board LEDs: accepts one packed N-channel sample per handshake,
//  applies a per-channel moving average, and compares each filtered magnitude to a
//  threshold with hysteresis. Drives one LED per channel, plus the dominant channel index
//  and that channel's sign.
// PARAMETERS
//  WIDTH     16    bits per channel sample, two's complement
//  CHANNELS  3     number of axes (ch0 = X, ch1 = Y, ch2 = Z)
//  AVG_LOG2  2     moving-average window = 2**AVG_LOG2 samples (>=1)
//  THRESH    4000  LED turn-on level: |avg| >= THRESH (unsigned, < 2**(WIDTH-1))
//  HYST      500   LED turn-off level: |avg| < THRESH-HYST (HYST <= THRESH)
// PORTS
//  MCLK          in   1                 system clock, rising edge
//  RESET         in   1                 asynchronous, active-low reset
//  SAMPLE_VALID  in   1                 SAMPLE_DATA holds a new sample
//  SAMPLE_DATA   in   CHANNELS*WIDTH    packed samples, ch0 in LSBs
//  SAMPLE_READY  out  1                 block can accept a sample (high only in IDLE)
//  LED           out  CHANNELS          per-channel threshold indicator
//  LEDSIGN       out  1                 1 = dominant channel average is negative
//  DOM_CH        out  $clog2(CHANNELS)  index of largest |avg|
//  OUT_VALID     out  1                 one-cycle pulse when LED/LEDSIGN/DOM_CH update
// BEHAVIOUR
//  - Reset (RESET=0, async): LED=0, LEDSIGN=0, DOM_CH=0, OUT_VALID=0, FSM=IDLE,
//    ring buffers, running sums and write pointer = 0. SAMPLE_READY=1 from the first
//    clock after release. Reset mid-operation aborts the sample; no partial update.
//  - FSM: IDLE -> PROC -> UPDATE -> IDLE.
//    IDLE: SAMPLE_READY=1; on VALID&READY, capture SAMPLE_DATA, ch=0, go to PROC.
//    PROC: exactly one channel per cycle, ch 0..CHANNELS-1; after last channel, go to UPDATE.
//    UPDATE: register outputs, pulse OUT_VALID, advance ring write pointer (mod window), go to IDLE.
//  - Latency: OUT_VALID rises CHANNELS+1 cycles after the accepting edge. Max throughput
//    is one sample per CHANNELS+2 cycles. VALID while READY=0 is ignored; nothing is queued.
//  - Per channel in PROC:
//    sum += new - oldest; oldest <= new.
//    sum width is WIDTH+AVG_LOG2, signed.
//    avg = sum >>> AVG_LOG2 (arithmetic shift, floor).
//  - Startup: buffers are zero, so avg ramps over the first 2**AVG_LOG2 samples.
//  - mag = |avg|; avg = -2**(WIDTH-1) saturates to 2**(WIDTH-1)-1 (no wrap).
//  - LED hysteresis per channel:
//    set if mag >= THRESH; clear if mag < THRESH-HYST; otherwise hold.
//    Evaluated into a shadow register; LED copies it in UPDATE.
//  - Dominant channel: strictly greater mag wins; ties keep the lower index.
//    LEDSIGN = sign bit of the dominant avg.
//  - Simultaneous VALID and reset release: the sample is not accepted on the release edge.
// CONFIGURATION
//  MPU_MON_FILTER_EN defined:
//    moving average as above; ring buffers of CHANNELS x 2**AVG_LOG2 x WIDTH.
//  MPU_MON_FILTER_EN undefined:
//    avg = raw captured sample; no ring buffers or sums; AVG_LOG2 ignored.
//    Latency, handshake, hysteresis and dominance rules are unchanged.
// TESTING
//  1 Reset: hold RESET=0 with VALID=1 -> LED=0, LEDSIGN=0, DOM_CH=0, OUT_VALID=0;
//    after release, SAMPLE_READY=1 and no OUT_VALID until a handshake.
//  2 Ramp (filter on, defaults): X=+8000 four times, Y=Z=0
//    -> avg X = 2000, 4000, 6000, 8000; LED[0] first set on the 2nd sample;
//    OUT_VALID exactly 4 cycles after each accept.
//  3 Hysteresis (filter off): X = 4100, 3700, 3400
//    -> LED[0] = 1, 1 (hold), 0.
//  4 Sign/dominance (filter off): X=5000, Y=-12000, Z=12000
//    -> DOM_CH=1 (tie, lower index wins), LEDSIGN=1, LED=3'b111.
//  5 Saturation (filter off): Z=-32768
//    -> mag 32767, LED[2]=1, DOM_CH=2, LEDSIGN=1, no wrap to 0.
//  6 Abort and backpressure:
//    VALID held through PROC -> exactly one accept per CHANNELS+2 cycles;
//    RESET=0 mid-PROC -> outputs clear immediately; next sample avg = raw>>>AVG_LOG2.

Source files
------------

// File: rtl/mpu_axis_monitor.sv
// mpu_axis_monitor: threshold/hysteresis monitor for packed N-axis MPU6050 samples.
// Optional moving-average filter enabled by defining MPU_MON_FILTER_EN; without it
// each channel is judged on the raw captured sample.
//
//  state    | meaning
//  S_IDLE   | SAMPLE_READY high, waiting for a handshake
//  S_PROC   | one channel per cycle: filter, magnitude, hysteresis, dominance
//  S_UPDATE | publish LED/LEDSIGN/DOM_CH, pulse OUT_VALID, advance ring pointer
module mpu_axis_monitor #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 3,
  parameter int AVG_LOG2 = 2,
  parameter int THRESH   = 4000,
  parameter int HYST     = 500,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      MCLK,
  input  logic                      RESET,
  input  logic                      SAMPLE_VALID,
  input  logic [CHANNELS*WIDTH-1:0] SAMPLE_DATA,
  output logic                      SAMPLE_READY,
  output logic [CHANNELS-1:0]       LED,
  output logic                      LEDSIGN,
  output logic [CH_W-1:0]           DOM_CH,
  output logic                      OUT_VALID
);

  // Averages are carried at accumulator width so -2**(WIDTH-1) can be negated safely.
  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam logic [WIDTH-1:0] THR_ON  = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] THR_OFF = WIDTH'(THRESH - HYST);
  localparam logic signed [ACC_W-1:0] MAG_MAX = {{(AVG_LOG2+1){1'b0}}, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_UPDATE} state_t;

  state_t                    state_q, state_d;
  logic                      armed_q, armed_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic [CHANNELS-1:0]       shadow_q, shadow_d;
  logic [CHANNELS-1:0]       led_q, led_d;
  logic [WIDTH-1:0]          best_mag_q, best_mag_d;
  logic [CH_W-1:0]           best_ch_q, best_ch_d;
  logic                      best_sign_q, best_sign_d;
  logic [CH_W-1:0]           dom_q, dom_d;
  logic                      ledsign_q, ledsign_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [WIDTH-1:0]   samp;
  logic signed [ACC_W-1:0]   avg_ext;
  logic signed [ACC_W-1:0]   mag_ext;
  logic [WIDTH-1:0]          mag;

`ifdef MPU_MON_FILTER_EN
  localparam int WIN = 2**AVG_LOG2;
  logic signed [WIDTH-1:0] ring_q [CHANNELS][WIN];
  logic signed [WIDTH-1:0] ring_d [CHANNELS][WIN];
  logic signed [ACC_W-1:0] sum_q  [CHANNELS];
  logic signed [ACC_W-1:0] sum_d  [CHANNELS];
  logic [AVG_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
  logic signed [ACC_W-1:0] sum_new;
`endif

  // armed_q keeps READY low on the reset-release edge so no sample is taken there.
  assign SAMPLE_READY = armed_q && (state_q == S_IDLE);
  assign LED          = led_q;
  assign LEDSIGN      = ledsign_q;
  assign DOM_CH       = dom_q;
  assign OUT_VALID    = out_valid_q;

  // Next-state, per-channel datapath and output staging.
  always_comb begin
    state_d     = state_q;
    armed_d     = 1'b1;
    ch_d        = ch_q;
    data_d      = data_q;
    shadow_d    = shadow_q;
    led_d       = led_q;
    best_mag_d  = best_mag_q;
    best_ch_d   = best_ch_q;
    best_sign_d = best_sign_q;
    dom_d       = dom_q;
    ledsign_d   = ledsign_q;
    out_valid_d = 1'b0;

    samp = data_q[ch_q*WIDTH +: WIDTH];
`ifdef MPU_MON_FILTER_EN
    ring_d   = ring_q;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    // Slot at wr_ptr holds the oldest sample of the window for this channel.
    sum_new  = sum_q[ch_q] + ACC_W'(samp) - ACC_W'(ring_q[ch_q][wr_ptr_q]);
    avg_ext  = sum_new >>> AVG_LOG2;
`else
    avg_ext  = ACC_W'(samp);
`endif
    mag_ext = avg_ext[ACC_W-1] ? -avg_ext : avg_ext;
    mag     = (mag_ext > MAG_MAX) ? MAG_MAX[WIDTH-1:0] : mag_ext[WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        if (SAMPLE_VALID && SAMPLE_READY) begin
          data_d  = SAMPLE_DATA;
          ch_d    = '0;
          state_d = S_PROC;
        end
      end
      S_PROC: begin
`ifdef MPU_MON_FILTER_EN
        sum_d[ch_q]            = sum_new;
        ring_d[ch_q][wr_ptr_q] = samp;
`endif
        if (mag >= THR_ON) begin
          shadow_d[ch_q] = 1'b1;
        end else if (mag < THR_OFF) begin
          shadow_d[ch_q] = 1'b0;
        end
        // Strictly greater wins, so ties stay with the lower channel index.
        if ((ch_q == '0) || (mag > best_mag_q)) begin
          best_mag_d  = mag;
          best_ch_d   = ch_q;
          best_sign_d = avg_ext[ACC_W-1];
        end
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = S_UPDATE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      S_UPDATE: begin
        led_d       = shadow_q;
        dom_d       = best_ch_q;
        ledsign_d   = best_sign_q;
        out_valid_d = 1'b1;
`ifdef MPU_MON_FILTER_EN
        wr_ptr_d    = wr_ptr_q + 1'b1;
`endif
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      ch_q        <= '0;
      data_q      <= '0;
      shadow_q    <= '0;
      led_q       <= '0;
      best_mag_q  <= '0;
      best_ch_q   <= '0;
      best_sign_q <= 1'b0;
      dom_q       <= '0;
      ledsign_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
      shadow_q    <= shadow_d;
      led_q       <= led_d;
      best_mag_q  <= best_mag_d;
      best_ch_q   <= best_ch_d;
      best_sign_q <= best_sign_d;
      dom_q       <= dom_d;
      ledsign_q   <= ledsign_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MPU_MON_FILTER_EN
  // Moving-average history, running sums and write pointer.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= '0;
        for (int w = 0; w < WIN; w++) begin
          ring_q[c][w] <= '0;
        end
      end
      wr_ptr_q <= '0;
    end else begin
      ring_q   <= ring_d;
      sum_q    <= sum_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_mpu_axis_monitor.sv
// Bench for mpu_axis_monitor: directed scenarios plus random samples checked against
// a queue-based reference of the averaging/hysteresis/dominance rules.
module tb_mpu_axis_monitor;

  localparam int W   = 16;
  localparam int C   = 3;
  localparam int L   = 2;
  localparam int TH  = 4000;
  localparam int HY  = 500;
  localparam int LAT = C + 1;
`ifdef MPU_MON_FILTER_EN
  localparam int WIN = 1 << L;
`else
  localparam int WIN = 1;
`endif

  logic           MCLK;
  logic           RESET;
  logic           SAMPLE_VALID;
  logic [C*W-1:0] SAMPLE_DATA;
  logic           SAMPLE_READY;
  logic [C-1:0]   LED;
  logic           LEDSIGN;
  logic [1:0]     DOM_CH;
  logic           OUT_VALID;

  int checks   = 0;
  int failures = 0;

  int       hist [C][$];
  bit [C-1:0] exp_led;
  int       exp_dom;
  bit       exp_sign;

  mpu_axis_monitor #(
    .WIDTH(W), .CHANNELS(C), .AVG_LOG2(L), .THRESH(TH), .HYST(HY)
  ) dut (
    .MCLK(MCLK), .RESET(RESET), .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_DATA(SAMPLE_DATA),
    .SAMPLE_READY(SAMPLE_READY), .LED(LED), .LEDSIGN(LEDSIGN), .DOM_CH(DOM_CH),
    .OUT_VALID(OUT_VALID)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < C; c++) begin
      hist[c].delete();
      for (int i = 0; i < WIN; i++) hist[c].push_back(0);
    end
    exp_led  = '0;
    exp_dom  = 0;
    exp_sign = 1'b0;
  endfunction

  function automatic void model_apply(input int s0, input int s1, input int s2);
    int s [C];
    int best;
    s = '{s0, s1, s2};
    best = -1;
    for (int c = 0; c < C; c++) begin
      int sum, avg, mag;
      hist[c].push_back(s[c]);
      void'(hist[c].pop_front());
      sum = 0;
      foreach (hist[c][i]) sum += hist[c][i];
      avg = floor_div(sum, WIN);
      mag = (avg < 0) ? -avg : avg;
      if (mag > 32767) mag = 32767;
      if (mag >= TH) exp_led[c] = 1'b1;
      else if (mag < TH - HY) exp_led[c] = 1'b0;
      if (mag > best) begin
        best     = mag;
        exp_dom  = c;
        exp_sign = (avg < 0);
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_led"},  {29'd0, LED},    {29'd0, exp_led});
    check({tag, "_dom"},  {30'd0, DOM_CH}, exp_dom);
    check({tag, "_sign"}, {31'd0, LEDSIGN}, {31'd0, exp_sign});
  endtask

  task automatic do_reset();
    SAMPLE_VALID = 1'b0;
    RESET = 1'b0;
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b1;
    model_reset();
    @(posedge MCLK);
    #1;
  endtask

  task automatic wait_out_valid(input string tag);
    int lat;
    lat = 0;
    while (!OUT_VALID && lat < 20) begin
      @(posedge MCLK);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_ready_after"}, {31'd0, SAMPLE_READY}, 1);
    check_outputs(tag);
    @(posedge MCLK);
    #1;
    check({tag, "_pulse_width"}, {31'd0, OUT_VALID}, 0);
  endtask

  task automatic send(input string tag, input int x, input int y, input int z);
    int n;
    SAMPLE_DATA  = {W'(z), W'(y), W'(x)};
    SAMPLE_VALID = 1'b1;
    n = 0;
    while (!SAMPLE_READY && n < 50) begin
      @(negedge MCLK);
      n++;
    end
    check({tag, "_ready_wait"}, {31'd0, SAMPLE_READY}, 1);
    @(posedge MCLK);
    #1;
    SAMPLE_VALID = 1'b0;
    model_apply(x, y, z);
    wait_out_valid(tag);
  endtask

  function automatic int rnd_val();
    int k, m;
    k = $urandom_range(0, 4);
    case (k)
      0:       return int'($urandom_range(0, 65535)) - 32768;
      1:       m = $urandom_range(3300, 4300);
      2:       m = $urandom_range(0, 300);
      3:       return -32768;
      default: m = $urandom_range(3450, 4050);
    endcase
    return ($urandom_range(0, 1) == 1) ? -m : m;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts, last, cyc, gap_bad;
    bit acc;
    int bx, by, bz;

    // Reset held with VALID asserted.
    RESET        = 1'b0;
    SAMPLE_VALID = 1'b1;
    SAMPLE_DATA  = {16'sd12000, 16'sd9000, 16'sd7000};
    model_reset();
    repeat (3) @(posedge MCLK);
    #1;
    check("rst_led",       {29'd0, LED}, 0);
    check("rst_ledsign",   {31'd0, LEDSIGN}, 0);
    check("rst_dom",       {30'd0, DOM_CH}, 0);
    check("rst_out_valid", {31'd0, OUT_VALID}, 0);
    // Release coincident with a clock edge while VALID is high.
    @(posedge MCLK);
    RESET = 1'b1;
    #1;
    SAMPLE_VALID = 1'b0;
    @(posedge MCLK);
    #1;
    check("rst_ready_after_release", {31'd0, SAMPLE_READY}, 1);
    for (int i = 0; i < 8; i++) begin
      check("rst_no_out_valid", {31'd0, OUT_VALID}, 0);
      @(posedge MCLK);
      #1;
    end

    // Ramp on X.
    do_reset();
    for (int i = 0; i < 4; i++) send("ramp", 8000, 0, 0);

    // Hysteresis band on X.
    do_reset();
    send("hyst_a", 4100, 0, 0);
    send("hyst_b", 3700, 0, 0);
    send("hyst_c", 3400, 0, 0);

    // Sign and tie-break.
    do_reset();
    send("dom_tie", 5000, -12000, 12000);

    // Most negative value saturates rather than wrapping.
    do_reset();
    send("sat", 0, 0, -32768);

    // VALID held continuously: accepts spaced by C+2 cycles.
    do_reset();
    bx = 20000 + $urandom_range(0, 10000);
    by = rnd_val();
    bz = rnd_val();
    SAMPLE_DATA  = {W'(bz), W'(by), W'(bx)};
    SAMPLE_VALID = 1'b1;
    accepts = 0;
    last    = -1;
    cyc     = 0;
    gap_bad = 0;
    while (accepts < 4 && cyc < 100) begin
      @(negedge MCLK);
      acc = SAMPLE_READY && SAMPLE_VALID;
      @(posedge MCLK);
      cyc++;
      if (acc) begin
        if (last >= 0 && (cyc - last) != C + 2) gap_bad++;
        last = cyc;
        accepts++;
        model_apply(bx, by, bz);
      end
    end
    #1;
    SAMPLE_VALID = 1'b0;
    check("bp_accepts", accepts, 4);
    check("bp_gap_errors", gap_bad, 0);
    wait_out_valid("bp");

    // Reset in the middle of PROC.
    SAMPLE_DATA  = {16'sd15000, -16'sd15000, 16'sd25000};
    SAMPLE_VALID = 1'b1;
    @(negedge MCLK);
    @(posedge MCLK);
    #1;
    SAMPLE_VALID = 1'b0;
    @(posedge MCLK);
    #1;
    RESET = 1'b0;
    #1;
    check("abort_led",       {29'd0, LED}, 0);
    check("abort_ledsign",   {31'd0, LEDSIGN}, 0);
    check("abort_dom",       {30'd0, DOM_CH}, 0);
    check("abort_out_valid", {31'd0, OUT_VALID}, 0);
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge MCLK);
      #1;
      check("abort_no_out_valid", {31'd0, OUT_VALID}, 0);
    end
    send("abort_next", 24000, -9000, 3000);

    // Random samples against the reference.
    for (int i = 0; i < 24; i++) begin
      int rx, ry, rz;
      rx = rnd_val();
      ry = rnd_val();
      rz = rnd_val();
      send("rand", rx, ry, rz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
